wb_stage: RTL and testbench

- Writeback stage of the RV32I core; sits directly upstream of the register file and drives its write port (rd, write data, write enable).
- Accepts one retiring instruction per handshake from the memory stage.
- Passes ALU results straight through; for loads, waits for the data-bus response, then lane-selects and sign- or zero-extends the data before writing.
- Signals load faults and backpressures the memory stage while a load is outstanding.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_stage_load_align.sv | 38 +++
 rtl/wb_stage.sv | 124 ++++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings,
// FSM state encoding and the datapath width.
package wb_pkg;

  localparam int XLEN_DEF = 32;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback FSM states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_LD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the byte/half/word addressed by the load,
// then sign- or zero-extends it. Flags funct3 codes that are not loads.
import wb_pkg::*;

module load_align (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_illegal
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by full offset, half by offset bit 1 only
  always_comb begin
    w_shifted = i_data >> {i_off, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = i_off[1] ? i_data[31:16] : i_data[15:0];
  end

  // Extension by load type; unsupported encodings raise the illegal flag
  always_comb begin
    o_data    = 32'h0000_0000;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0000, w_half};
      F3_LW:   o_data = i_data;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage. Drives the register-file write port, forwards
// ALU results with one cycle of latency and stalls the memory stage while
// a load waits for its data-bus response.
// Optional: define WB_RETIRE_CNT_EN to add the 64-bit instret_o counter.
import wb_pkg::*;

module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [4:0]      rd_i,
  input  logic            rd_we_i,
  input  logic [XLEN-1:0] result_i,
  input  logic            is_load_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            dbus_ack_i,
  input  logic            dbus_err_i,
  input  logic [XLEN-1:0] dbus_dat_i,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rf_wd_o,
  output logic            we_o,
  output logic            load_fault_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     instret_o
`endif
);

  wb_state_t   r_state;
  logic [4:0]  r_rd;
  logic        r_rd_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic [31:0] w_aligned;
  logic        w_illegal;
  logic        w_fire;
  logic        w_ld_done;
  logic        w_ld_bad;

  load_align u_align (
    .i_funct3  (r_funct3),
    .i_off     (r_off),
    .i_data    (dbus_dat_i),
    .o_data    (w_aligned),
    .o_illegal (w_illegal)
  );

  // Ready depends only on state (and is held low during reset)
  assign mem_ready_o = rst_i && (r_state == ST_IDLE);
  assign w_fire      = mem_valid_i && mem_ready_o;
  assign w_ld_done   = (r_state == ST_WAIT_LD) && dbus_ack_i;
  assign w_ld_bad    = dbus_err_i || w_illegal;

  // FSM with registered register-file outputs; rd/data only move on a write
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      we_o         <= 1'b0;
      load_fault_o <= 1'b0;
      rd_o         <= 5'd0;
      rf_wd_o      <= '0;
      r_rd         <= 5'd0;
      r_rd_we      <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
    end else begin
      we_o         <= 1'b0;
      load_fault_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            if (is_load_i) begin
              r_rd     <= rd_i;
              r_rd_we  <= rd_we_i;
              r_funct3 <= funct3_i;
              r_off    <= addr_lo_i;
              r_state  <= ST_WAIT_LD;
            end else if (rd_we_i && (rd_i != 5'd0)) begin
              we_o    <= 1'b1;
              rd_o    <= rd_i;
              rf_wd_o <= result_i;
            end
          end
        end
        ST_WAIT_LD: begin
          if (dbus_ack_i) begin
            r_state <= ST_IDLE;
            if (w_ld_bad) begin
              load_fault_o <= 1'b1;
            end else if (r_rd_we && (r_rd != 5'd0)) begin
              we_o    <= 1'b1;
              rd_o    <= r_rd;
              rf_wd_o <= w_aligned;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_instret;
  logic        w_retire;

  assign w_retire  = (w_fire && !is_load_i) || (w_ld_done && !w_ld_bad);
  assign instret_o = r_instret;

  // Retired-instruction counter; faulted loads are not counted
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_instret <= 64'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  rd = 5'd0;
  logic        rd_we = 1'b0;
  logic [31:0] result = 32'd0;
  logic        is_load = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [1:0]  addr_lo = 2'd0;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic [31:0] dat = 32'd0;
  logic [4:0]  rd_out;
  logic [31:0] wd_out;
  logic        we_out;
  logic        fault_out;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_valid_i  (mem_valid),
    .mem_ready_o  (mem_ready),
    .rd_i         (rd),
    .rd_we_i      (rd_we),
    .result_i     (result),
    .is_load_i    (is_load),
    .funct3_i     (funct3),
    .addr_lo_i    (addr_lo),
    .dbus_ack_i   (ack),
    .dbus_err_i   (err),
    .dbus_dat_i   (dat),
    .rd_o         (rd_out),
    .rf_wd_o      (wd_out),
    .we_o         (we_out),
    .load_fault_o (fault_out)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret_o    (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one load, wait in WAIT_LD for `waits` cycles, ack on the last one
  task automatic issue_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] r,
                            input int waits, input logic [31:0] d, input logic e);
    mem_valid = 1'b1; is_load = 1'b1; funct3 = f3; addr_lo = off; rd = r; rd_we = 1'b1;
    tick();
    mem_valid = 1'b0; is_load = 1'b0;
    for (int i = 1; i < waits; i++) tick();
    ack = 1'b1; dat = d; err = e;
    tick();
    ack = 1'b0; err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", mem_ready); end
    checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we_out); end
    checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault_out); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd_out); end
    checks++; if (wd_out !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h expected 00000000", wd_out); end
    rst = 1'b1;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_idle: got %b expected 1", mem_ready); end
    $display("reset: ready=%b we=%b rd=%0d wd=%h", mem_ready, we_out, rd_out, wd_out);
  endtask

  task automatic test_alu();
    mem_valid = 1'b1; is_load = 1'b0; rd = 5'd5; rd_we = 1'b1; result = 32'hDEADBEEF;
    tick();
    checks++; if (we_out !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", we_out); end
    checks++; if (rd_out !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d expected 5", rd_out); end
    checks++; if (wd_out !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wd: got %h expected deadbeef", wd_out); end
    $display("alu rd=5: we=%b rd=%0d wd=%h", we_out, rd_out, wd_out);
    rd = 5'd0; result = 32'h11111111;
    tick();
    checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL alu_rd0_we: got %b expected 0", we_out); end
    checks++; if (wd_out !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_rd0_hold: got %h expected deadbeef", wd_out); end
    $display("alu rd=0: we=%b wd=%h", we_out, wd_out);
    rd = 5'd6; rd_we = 1'b0;
    tick();
    checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL alu_nowe: got %b expected 0", we_out); end
    $display("alu rd_we=0: we=%b", we_out);
    mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h00000001; vals[1] = 32'hA5A5A5A5; vals[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, mem_ready); end
      mem_valid = 1'b1; is_load = 1'b0; rd_we = 1'b1; rd = 5'(i + 1); result = vals[i];
      tick();
      checks++; if (we_out !== 1'b1 || rd_out !== 5'(i + 1) || wd_out !== vals[i]) begin
        errors++; $display("FAIL b2b[%0d]: got we=%b rd=%0d wd=%h expected we=1 rd=%0d wd=%h", i, we_out, rd_out, wd_out, i + 1, vals[i]);
      end
      $display("b2b[%0d]: we=%b rd=%0d wd=%h", i, we_out, rd_out, wd_out);
    end
    mem_valid = 1'b0;
    tick();
    checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL b2b_idle_we: got %b expected 0", we_out); end
  endtask

  task automatic test_extend();
    logic [2:0]  f3s  [8];
    logic [1:0]  offs [8];
    logic [31:0] exps [8];
    f3s[0] = 3'b000; offs[0] = 2'd2; exps[0] = 32'hFFFFFFFF;
    f3s[1] = 3'b100; offs[1] = 2'd3; exps[1] = 32'h00000080;
    f3s[2] = 3'b001; offs[2] = 2'd2; exps[2] = 32'hFFFF80FF;
    f3s[3] = 3'b101; offs[3] = 2'd0; exps[3] = 32'h00007F01;
    f3s[4] = 3'b000; offs[4] = 2'd1; exps[4] = 32'h0000007F;
    f3s[5] = 3'b100; offs[5] = 2'd0; exps[5] = 32'h00000001;
    f3s[6] = 3'b101; offs[6] = 2'd2; exps[6] = 32'h000080FF;
    f3s[7] = 3'b001; offs[7] = 2'd1; exps[7] = 32'h00007F01;
    for (int i = 0; i < 8; i++) begin
      issue_load(f3s[i], offs[i], 5'd10, 1, 32'h80FF7F01, 1'b0);
      checks++; if (we_out !== 1'b1 || rd_out !== 5'd10 || wd_out !== exps[i]) begin
        errors++; $display("FAIL extend[%0d]: got we=%b rd=%0d wd=%h expected we=1 rd=10 wd=%h", i, we_out, rd_out, wd_out, exps[i]);
      end
      $display("load f3=%b off=%0d: we=%b wd=%h", f3s[i], offs[i], we_out, wd_out);
    end
  endtask

  task automatic test_load_stall();
    mem_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr_lo = 2'd3; rd = 5'd12; rd_we = 1'b1;
    tick();
    mem_valid = 1'b0; is_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_ready !== 1'b0 || we_out !== 1'b0) begin
        errors++; $display("FAIL stall[%0d]: got ready=%b we=%b expected ready=0 we=0", i, mem_ready, we_out);
      end
      $display("stall cycle %0d: ready=%b we=%b", i, mem_ready, we_out);
      if (i == 2) begin ack = 1'b1; dat = 32'h12345678; end
      tick();
    end
    ack = 1'b0;
    checks++; if (we_out !== 1'b1 || rd_out !== 5'd12 || wd_out !== 32'h12345678) begin
      errors++; $display("FAIL stall_lw: got we=%b rd=%0d wd=%h expected we=1 rd=12 wd=12345678", we_out, rd_out, wd_out);
    end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_after: got %b expected 1", mem_ready); end
    $display("stall done: we=%b wd=%h ready=%b", we_out, wd_out, mem_ready);
  endtask

  task automatic test_fault();
    logic [31:0] wd_before;
    wd_before = wd_out;
    issue_load(3'b010, 2'd0, 5'd13, 2, 32'hCAFEF00D, 1'b1);
    checks++; if (fault_out !== 1'b1 || we_out !== 1'b0) begin
      errors++; $display("FAIL fault_err: got fault=%b we=%b expected fault=1 we=0", fault_out, we_out);
    end
    checks++; if (wd_out !== wd_before) begin errors++; $display("FAIL fault_hold_wd: got %h expected %h", wd_out, wd_before); end
    $display("fault bus err: fault=%b we=%b", fault_out, we_out);
    tick();
    checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b expected 0", fault_out); end
    issue_load(3'b011, 2'd0, 5'd13, 1, 32'hCAFEF00D, 1'b0);
    checks++; if (fault_out !== 1'b1 || we_out !== 1'b0) begin
      errors++; $display("FAIL fault_f3_011: got fault=%b we=%b expected fault=1 we=0", fault_out, we_out);
    end
    $display("fault f3=011: fault=%b we=%b", fault_out, we_out);
    issue_load(3'b110, 2'd0, 5'd13, 1, 32'hCAFEF00D, 1'b0);
    checks++; if (fault_out !== 1'b1 || we_out !== 1'b0) begin
      errors++; $display("FAIL fault_f3_110: got fault=%b we=%b expected fault=1 we=0", fault_out, we_out);
    end
    $display("fault f3=110: fault=%b we=%b", fault_out, we_out);
    tick();
    checks++; if (fault_out !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL fault_recover: got fault=%b ready=%b expected fault=0 ready=1", fault_out, mem_ready);
    end
  endtask

  task automatic test_ack_idle();
    ack = 1'b1; err = 1'b1; dat = 32'h55555555;
    tick();
    ack = 1'b0; err = 1'b0;
    checks++; if (we_out !== 1'b0 || fault_out !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL ack_idle: got we=%b fault=%b ready=%b expected 0 0 1", we_out, fault_out, mem_ready);
    end
    $display("ack in idle: we=%b fault=%b ready=%b", we_out, fault_out, mem_ready);
  endtask

  task automatic test_reset_mid_load();
    mem_valid = 1'b1; is_load = 1'b1; funct3 = 3'b000; addr_lo = 2'd0; rd = 5'd9; rd_we = 1'b1;
    tick();
    mem_valid = 1'b0; is_load = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low: got %b expected 0", mem_ready); end
    tick();
    rst = 1'b1; ack = 1'b1; dat = 32'h000000AA;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", mem_ready); end
    tick();
    ack = 1'b0;
    checks++; if (we_out !== 1'b0 || fault_out !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_late_ack: got we=%b fault=%b ready=%b expected 0 0 1", we_out, fault_out, mem_ready);
    end
    $display("reset mid-load, late ack: we=%b fault=%b ready=%b", we_out, fault_out, mem_ready);
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL instret_reset: got %0d expected 0", instret); end
    mem_valid = 1'b1; is_load = 1'b0; rd_we = 1'b1; rd = 5'd1; result = 32'd7;
    tick(); tick(); tick();
    mem_valid = 1'b0;
    checks++; if (instret !== 64'd3) begin errors++; $display("FAIL instret_alu: got %0d expected 3", instret); end
    issue_load(3'b010, 2'd0, 5'd2, 2, 32'h1, 1'b0);
    issue_load(3'b010, 2'd0, 5'd2, 1, 32'h1, 1'b1);
    tick();
    checks++; if (instret !== 64'd4) begin errors++; $display("FAIL instret_total: got %0d expected 4", instret); end
    $display("instret after 3 alu + good load + faulted load: %0d", instret);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_extend();
    test_load_stall();
    test_fault();
    test_ack_idle();
    test_reset_mid_load();
`ifdef WB_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
